// File: rtl/oqpsk_pkg.sv
// Shared types and defaults for the O-QPSK I/Q splitter.
package oqpsk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2
  } state_t;

  localparam int SAMPLES_PER_CHIP_DEF = 4;
  localparam int CHIPS_PER_SYMBOL_DEF = 32;

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/oqpsk_iq_splitter_if.sv
// Chip-stream handshake plus I/Q output bundle of the O-QPSK splitter.
interface oqpsk_iq_splitter_if;

  logic i_sample_tick;
  logic i_chip;
  logic i_chip_valid;
  logic i_chip_last;
  logic o_chip_ready;
  logic o_i;
  logic o_q;
  logic o_i_en;
  logic o_q_en;
  logic o_busy;
  logic o_frame_done;
  logic o_underrun;
  logic o_len_err;

  modport master (
    output i_sample_tick, i_chip, i_chip_valid, i_chip_last,
    input  o_chip_ready, o_i, o_q, o_i_en, o_q_en, o_busy,
           o_frame_done, o_underrun, o_len_err
  );

  modport slave (
    input  i_sample_tick, i_chip, i_chip_valid, i_chip_last,
    output o_chip_ready, o_i, o_q, o_i_en, o_q_en, o_busy,
           o_frame_done, o_underrun, o_len_err
  );

endinterface

// File: rtl/oqpsk_chip_timer.sv
// Sample counter and chip-boundary strobe. In IDLE every tick is a boundary
// so a new frame can start on the first tick; otherwise a boundary is the
// last sample tick of a chip period.
module oqpsk_chip_timer
  import oqpsk_pkg::*;
#(
  parameter int SAMPLES_PER_CHIP = SAMPLES_PER_CHIP_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_clear,
  input  logic i_idle,
  output logic o_boundary
);

  localparam int CW = cnt_width(SAMPLES_PER_CHIP);
  localparam logic [CW-1:0] LAST_SAMPLE = CW'(SAMPLES_PER_CHIP - 1);

  logic [CW-1:0] sample_cnt;
  logic          at_last;

  assign at_last    = (sample_cnt == LAST_SAMPLE);
  assign o_boundary = i_tick && (i_idle || at_last);

  // counter parks at zero in IDLE and wraps at every chip boundary
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear || i_idle) begin
      sample_cnt <= '0;
    end else if (i_tick) begin
      sample_cnt <= at_last ? '0 : sample_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/oqpsk_iq_splitter.sv
// O-QPSK I/Q splitter: even chips to I, odd chips to Q, each held for two
// chip periods with Q trailing I by one chip period.
// Optional frame-length check enabled by defining IQ_FRAME_LEN_CHECK_EN.
//
//   state | meaning
//   IDLE  | waiting for the first chip; every sample tick is a boundary
//   RUN   | accepting one chip per boundary, alternating I and Q
//   TAIL  | last chip taken; flush one channel per boundary, then done
module oqpsk_iq_splitter
  import oqpsk_pkg::*;
#(
  parameter int SAMPLES_PER_CHIP = SAMPLES_PER_CHIP_DEF,
  parameter int CHIPS_PER_SYMBOL = CHIPS_PER_SYMBOL_DEF
) (
  input logic                i_clk,
  input logic                i_rst,
  oqpsk_iq_splitter_if.slave chip_if
);

  if (SAMPLES_PER_CHIP < 2 || CHIPS_PER_SYMBOL < 1) begin : g_param_check
    $error("oqpsk_iq_splitter: SAMPLES_PER_CHIP must be >= 2 and CHIPS_PER_SYMBOL >= 1");
  end

  state_t state;
  logic   parity;
  logic   tail_cnt;
  logic   i_r, q_r, i_en_r, q_en_r;
  logic   done_r, underrun_r;
  logic   boundary, ready, accept, abort, tail_end;

  oqpsk_chip_timer #(.SAMPLES_PER_CHIP(SAMPLES_PER_CHIP)) u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_tick     (chip_if.i_sample_tick),
    .i_clear    (abort || tail_end),
    .i_idle     (state == IDLE),
    .o_boundary (boundary)
  );

  // ready is suppressed under reset so no chip is consumed from a discarded frame
  assign ready    = boundary && !i_rst && (state != TAIL);
  assign accept   = ready && chip_if.i_chip_valid;
  assign abort    = boundary && (state == RUN) && !chip_if.i_chip_valid;
  assign tail_end = boundary && (state == TAIL) && tail_cnt;

  // chip steering, tail flush and underrun abort; all outputs registered
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      parity     <= 1'b0;
      tail_cnt   <= 1'b0;
      i_r        <= 1'b0;
      q_r        <= 1'b0;
      i_en_r     <= 1'b0;
      q_en_r     <= 1'b0;
      done_r     <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      underrun_r <= 1'b0;
      if (boundary) begin
        case (state)
          IDLE: begin
            if (chip_if.i_chip_valid) begin
              i_r      <= chip_if.i_chip;
              i_en_r   <= 1'b1;
              parity   <= 1'b1;
              tail_cnt <= 1'b0;
              state    <= chip_if.i_chip_last ? TAIL : RUN;
            end
          end
          RUN: begin
            if (chip_if.i_chip_valid) begin
              if (!parity) begin
                i_r    <= chip_if.i_chip;
                i_en_r <= 1'b1;
              end else begin
                q_r    <= chip_if.i_chip;
                q_en_r <= 1'b1;
              end
              parity <= ~parity;
              if (chip_if.i_chip_last) begin
                tail_cnt <= 1'b0;
                state    <= TAIL;
              end
            end else begin
              underrun_r <= 1'b1;
              i_r        <= 1'b0;
              q_r        <= 1'b0;
              i_en_r     <= 1'b0;
              q_en_r     <= 1'b0;
              parity     <= 1'b0;
              state      <= IDLE;
            end
          end
          TAIL: begin
            if (!tail_cnt) begin
              // parity points at the channel the last chip did not load
              tail_cnt <= 1'b1;
              if (parity) begin
                q_r    <= 1'b0;
                q_en_r <= 1'b0;
              end else begin
                i_r    <= 1'b0;
                i_en_r <= 1'b0;
              end
            end else begin
              tail_cnt <= 1'b0;
              i_r      <= 1'b0;
              q_r      <= 1'b0;
              i_en_r   <= 1'b0;
              q_en_r   <= 1'b0;
              parity   <= 1'b0;
              done_r   <= 1'b1;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef IQ_FRAME_LEN_CHECK_EN
  localparam int CCW = cnt_width(CHIPS_PER_SYMBOL);
  localparam logic [CCW-1:0] LAST_CHIP = CCW'(CHIPS_PER_SYMBOL - 1);

  logic [CCW-1:0] chip_cnt;
  logic           len_err_r;

  // counts accepted chips modulo a symbol; flags frames ending mid-symbol
  always_ff @(posedge i_clk) begin
    if (i_rst || abort) begin
      chip_cnt  <= '0;
      len_err_r <= 1'b0;
    end else begin
      len_err_r <= 1'b0;
      if (accept) begin
        if (chip_if.i_chip_last) begin
          len_err_r <= (chip_cnt != LAST_CHIP);
          chip_cnt  <= '0;
        end else begin
          chip_cnt <= (chip_cnt == LAST_CHIP) ? '0 : chip_cnt + 1'b1;
        end
      end
    end
  end

  assign chip_if.o_len_err = len_err_r;
`else
  assign chip_if.o_len_err = 1'b0;
`endif

  assign chip_if.o_chip_ready = ready;
  assign chip_if.o_i          = i_r;
  assign chip_if.o_q          = q_r;
  assign chip_if.o_i_en       = i_en_r;
  assign chip_if.o_q_en       = q_en_r;
  assign chip_if.o_busy       = (state != IDLE);
  assign chip_if.o_frame_done = done_r;
  assign chip_if.o_underrun   = underrun_r;

endmodule

// File: tb/tb_oqpsk_iq_splitter.sv
// Directed bench for oqpsk_iq_splitter with a chip scoreboard.
module tb_oqpsk_iq_splitter;

  localparam int SPC = 4;
  localparam int CPS = 32;
`ifdef IQ_FRAME_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif
  localparam logic [63:0] PAT_A = 64'h5A3C_96E1_0FF0_C3AD;

  typedef struct {
    logic is_q;
    logic val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mism = 0;
  int   n_done = 0;
  int   n_unr = 0;
  int   n_len = 0;

  oqpsk_iq_splitter_if bus ();

  oqpsk_iq_splitter #(.SAMPLES_PER_CHIP(SPC), .CHIPS_PER_SYMBOL(CPS)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .chip_if (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mism++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock and sample just after the edge, tallying pulses
  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (bus.o_frame_done === 1'b1) n_done++;
    if (bus.o_underrun === 1'b1) n_unr++;
    if (bus.o_len_err === 1'b1) n_len++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_sample_tick = 1'b1;
      bus.i_chip_valid  = 1'b0;
      bus.i_chip_last   = 1'b0;
      bus.i_chip        = 1'b0;
      next_cycle();
    end
  endtask

  // Sends chips pat[0..n-1] with a tick every div cycles. drop_at>=0 removes
  // valid from that chip on; rst_at>=0 pulses reset in that frame cycle.
  task automatic send_frame(input string name, input int n, input int div,
                            input int drop_at, input int rst_at, input logic [63:0] pat);
    int   k, last_acc_cyc, t_last, i_fall, q_fall, busy_low, budget, exp_acc;
    int   done0, unr0, len0, per;
    logic acc, finished, last_q;
    logic exp_i, exp_q, exp_ie, exp_qe;
    exp_t e;
    k = 0; last_acc_cyc = -1; t_last = -1; i_fall = -1; q_fall = -1; busy_low = 0;
    exp_i = 1'b0; exp_q = 1'b0; exp_ie = 1'b0; exp_qe = 1'b0; finished = 1'b0;
    done0 = n_done; unr0 = n_unr; len0 = n_len;
    per = SPC * div;
    budget = (n + 4) * per + 40;
    last_q = ((n - 1) % 2) == 1;
    for (int c = 0; c < budget; c++) begin
      bus.i_sample_tick = (c % div) == 0;
      bus.i_chip_valid  = (k < n) && !(drop_at >= 0 && k >= drop_at);
      bus.i_chip        = pat[k % 64];
      bus.i_chip_last   = (k == n - 1);
      rst               = (c == rst_at);
      #1;
      acc = bus.o_chip_ready && bus.i_chip_valid;
      if (acc) sb.push_back('{is_q: 1'(k % 2), val: pat[k % 64]});
      next_cycle();
      if (c == rst_at) begin
        chk({name, ".rst_clear"}, 32'({bus.o_i, bus.o_q, bus.o_i_en, bus.o_q_en, bus.o_busy,
                                        bus.o_frame_done, bus.o_underrun}), 32'd0);
        rst = 1'b0;
        finished = 1'b1;
        break;
      end
      if (bus.o_underrun === 1'b1) begin
        chk({name, ".unr_time"}, 32'(c - last_acc_cyc), 32'(per));
        chk({name, ".unr_clear"}, 32'({bus.o_i, bus.o_q, bus.o_i_en, bus.o_q_en, bus.o_busy}), 32'd0);
        finished = 1'b1;
        break;
      end
      if (acc) begin
        if (last_acc_cyc >= 0) chk({name, ".chip_period"}, 32'(c - last_acc_cyc), 32'(per));
        last_acc_cyc = c;
        e = sb.pop_front();
        if (e.is_q) begin
          exp_q = e.val; exp_qe = 1'b1;
        end else begin
          exp_i = e.val; exp_ie = 1'b1;
        end
        k++;
      end
      if (last_acc_cyc >= 0 && t_last < 0)
        chk({name, ".iq"}, 32'({bus.o_i, bus.o_q, bus.o_i_en, bus.o_q_en, bus.o_busy}),
            32'({exp_i, exp_q, exp_ie, exp_qe, 1'b1}));
      if (acc && k == n) begin
        t_last = c;
        chk({name, ".len_err"}, 32'(bus.o_len_err), 32'(LEN_CHK && (n % CPS) != 0));
      end
      if (t_last >= 0 && c > t_last) begin
        if (i_fall < 0 && !bus.o_i_en) i_fall = c - t_last;
        if (exp_qe && q_fall < 0 && !bus.o_q_en) q_fall = c - t_last;
        if (!bus.o_frame_done && !bus.o_busy) busy_low++;
      end
      if (bus.o_frame_done === 1'b1) begin
        chk({name, ".done_time"}, 32'(c - t_last), 32'(2 * per));
        chk({name, ".i_fall"}, 32'(i_fall), 32'(last_q ? per : 2 * per));
        chk({name, ".q_fall"}, 32'(q_fall), (n == 1) ? 32'hFFFF_FFFF : 32'(last_q ? 2 * per : per));
        chk({name, ".busy_gap"}, 32'(busy_low), 32'd0);
        finished = 1'b1;
        break;
      end
    end
    chk({name, ".terminated"}, 32'(finished), 32'd1);
    idle_cycles(8);
    if (drop_at >= 0) exp_acc = drop_at;
    else if (rst_at >= 0) exp_acc = (rst_at - 1) / per + 1;
    else exp_acc = n;
    chk({name, ".accepted"}, 32'(k), 32'(exp_acc));
    chk({name, ".done_cnt"}, 32'(n_done - done0), 32'((drop_at < 0 && rst_at < 0) ? 1 : 0));
    chk({name, ".unr_cnt"}, 32'(n_unr - unr0), 32'((drop_at >= 0) ? 1 : 0));
    chk({name, ".len_cnt"}, 32'(n_len - len0),
        32'((LEN_CHK && drop_at < 0 && rst_at < 0 && (n % CPS) != 0) ? 1 : 0));
    chk({name, ".idle_outs"}, 32'({bus.o_i, bus.o_q, bus.o_i_en, bus.o_q_en, bus.o_busy}), 32'd0);
  endtask

  initial begin
    logic [63:0] rnd;
    rst = 1'b1;
    bus.i_sample_tick = 1'b1;
    bus.i_chip_valid  = 1'b0;
    bus.i_chip        = 1'b0;
    bus.i_chip_last   = 1'b0;

    // reset with ticks running
    repeat (3) next_cycle();
    #1;
    chk("reset_outs", 32'({bus.o_chip_ready, bus.o_i, bus.o_q, bus.o_i_en, bus.o_q_en, bus.o_busy,
                           bus.o_frame_done, bus.o_underrun, bus.o_len_err}), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.i_sample_tick = 1'b1;
      bus.i_chip_valid  = 1'b0;
      #1;
      chk("idle_ready", 32'(bus.o_chip_ready), 32'd1);
      next_cycle();
      chk("idle_no_accept", 32'({bus.o_i_en, bus.o_q_en, bus.o_busy}), 32'd0);
    end

    send_frame("f32", 32, 1, -1, -1, PAT_A);
    send_frame("underrun", 32, 1, 10, -1, PAT_A);
    send_frame("one_chip", 1, 1, -1, -1, 64'h1);
    rnd = {$urandom, $urandom};
    send_frame("div3", 6, 3, -1, -1, rnd);
    rnd = {$urandom, $urandom};
    send_frame("rst_mid", 8, 3, -1, 40, rnd);
    send_frame("odd5", 5, 1, -1, -1, PAT_A);
    rnd = {$urandom, $urandom};
    send_frame("len30", 30, 1, -1, -1, rnd);
    rnd = {$urandom, $urandom};
    send_frame("len64", 64, 1, -1, -1, rnd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
    $finish;
  end

endmodule
